lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter SIZE_LOG2, default 13, word-address width of the attached word-wide synchronous RAM.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  LSU accepts a request; a transfer occurs when req_valid & req_ready are high at a rising edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU apply to loads only.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  request rejected (misaligned or illegal size code); valid with rsp_valid.
REQ-013 mem_we  output  1  RAM write enable.
REQ-014 mem_a  output  SIZE_LOG2  RAM word address.
REQ-015 mem_wd  output  32  RAM write data.
REQ-016 mem_rd  input  32  RAM read data, valid the cycle after mem_a is presented.

Function
REQ-017 States SHALL be IDLE, LOAD, RMW, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-018 Word address SHALL be req_addr[SIZE_LOG2+1:2]; address bits above this SHALL be ignored, so addresses wrap.
REQ-019 Error SHALL be raised for funct3 in {011,110,111}, for store funct3 in {100,101}, for H/HU with addr[0]=1, and for W with addr[1:0]!=0.
REQ-020 On an accepted error request: no RAM write; next state RESP with rsp_err=1 and rsp_rdata=0.
REQ-021 On an accepted load: mem_a driven combinationally from req_addr in the accept cycle; next state LOAD.
REQ-022 In LOAD: the byte or halfword at the registered offset SHALL be selected from mem_rd, sign-extended (B,H) or zero-extended (BU,HU), and registered into rsp_rdata; next state RESP.
REQ-023 On an accepted SW: mem_we=1, mem_a=word address and mem_wd=req_wdata in the accept cycle; next state RESP.
REQ-024 On an accepted SB/SH: RAM read issued in the accept cycle with mem_we=0; next state RMW.
REQ-025 In RMW: mem_we=1 and mem_a=registered word address; mem_wd = mem_rd with only the addressed byte(s) replaced by the low byte/halfword of the registered wdata; next state RESP.
REQ-026 In RESP: rsp_valid=1 for exactly one cycle; next state IDLE.
REQ-027 Latency from accept edge to rsp_valid: load 2 cycles, SB/SH 2 cycles, SW 1 cycle, error 1 cycle.
REQ-028 mem_we SHALL be 0 in all cycles other than a SW accept cycle or an RMW cycle.
REQ-029 Request inputs SHALL be ignored outside IDLE; an accept in IDLE SHALL NOT use any stale registered request data.
REQ-030 mem_a, mem_wd and mem_we SHALL hold no X-dependent values; in IDLE with no request, mem_a=0 and mem_wd=0.

Reset
REQ-031 While rst=1: req_ready=0, rsp_valid=0, mem_we=0; at the next edge state SHALL be IDLE and rsp_rdata=0, rsp_err=0.
REQ-032 Reset asserted in LOAD, RMW or RESP SHALL abort the operation: no RAM write, no rsp_valid pulse.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF -> mem_we=1, mem_a=4, mem_wd=0xDEADBEEF in accept cycle; rsp_valid next cycle with rsp_err=0.
REQ-034 After that, LB addr 0x13 -> rsp_rdata=0xFFFFFFDE two cycles after accept; LBU addr 0x13 -> 0x000000DE; LHU addr 0x10 -> 0x0000BEEF.
REQ-035 SH addr 0x12 data 0x00001234 over 0xDEADBEEF -> RMW writes 0x1234BEEF to mem_a=4; a later LW addr 0x10 returns 0x1234BEEF.
REQ-036 LW addr 0x11 and SH addr 0x13 -> rsp_err=1, rsp_rdata=0, mem_we never 1, rsp_valid one cycle after accept.
REQ-037 Reset asserted in the RMW cycle of SB addr 0x20 -> mem_we=0, no rsp_valid; word at mem_a=8 unchanged; req_ready=1 in the first cycle after reset release.
REQ-038 req_valid held high continuously with back-to-back loads -> req_ready high only in IDLE, one response per request, in order.

Source files
------------

// File: rtl/lsu_if.sv
// Request, response and RAM-side signals of the load/store unit, bundled
// so that the LSU and whoever drives it share one set of connections.
interface lsu_if #(
    parameter int SIZE_LOG2 = 13
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 mem_we;
    logic [SIZE_LOG2-1:0] mem_a;
    logic [31:0]          mem_wd;
    logic [31:0]          mem_rd;

    // Core / RAM side: issues requests, supplies RAM read data
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
    );

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit in front of a word-wide synchronous RAM. Handles RISC-V
// byte/halfword/word accesses: sub-word loads are extracted and extended,
// sub-word stores go through a read-modify-write of the containing word,
// and misaligned or illegal requests are answered with an error response.
module lsu #(
    parameter int SIZE_LOG2 = 13
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RMW  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e               state_q,  state_d;
    logic [1:0]           off_q,    off_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [31:0]          wdata_q,  wdata_d;
    logic [SIZE_LOG2-1:0] waddr_q,  waddr_d;
    logic [31:0]          rdata_q,  rdata_d;
    logic                 err_q,    err_d;

    logic [SIZE_LOG2-1:0] req_waddr_s;
    logic                 accept_s;
    logic                 req_err_s;

    // Decide whether a request must be rejected (bad size code or misaligned)
    function automatic logic req_error(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Pick the addressed byte/halfword out of a RAM word and extend it
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/halfword of the old RAM word
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] m;
        m = old;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    m[7:0]   = wd[7:0];
                    2'd1:    m[15:8]  = wd[7:0];
                    2'd2:    m[23:16] = wd[7:0];
                    2'd3:    m[31:24] = wd[7:0];
                    default: m = old;
                endcase
            end
            3'b001: begin
                if (off[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0]  = wd[15:0];
                end
            end
            default: m = old;
        endcase
        return m;
    endfunction

    // Request decode: word address (upper address bits dropped so it wraps),
    // handshake and error classification
    always_comb begin
        req_waddr_s = bus.req_addr[SIZE_LOG2+1:2];
        accept_s    = bus.req_valid && (state_q == ST_IDLE) && !rst;
        req_err_s   = req_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    end

    // Next-state logic, request capture and RAM/response outputs
    always_comb begin
        state_d        = state_q;
        off_d          = off_q;
        funct3_d       = funct3_q;
        wdata_d        = wdata_q;
        waddr_d        = waddr_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_a      = '0;
        bus.mem_wd     = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = !rst;
                if (accept_s) begin
                    // Every field used later is recaptured here, so nothing
                    // from an earlier request can leak into this one.
                    off_d    = bus.req_addr[1:0];
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata;
                    waddr_d  = req_waddr_s;
                    rdata_d  = 32'h0000_0000;
                    if (req_err_s) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!bus.req_we) begin
                        err_d     = 1'b0;
                        bus.mem_a = req_waddr_s;
                        state_d   = ST_LOAD;
                    end else if (bus.req_funct3 == 3'b010) begin
                        err_d      = 1'b0;
                        bus.mem_we = 1'b1;
                        bus.mem_a  = req_waddr_s;
                        bus.mem_wd = bus.req_wdata;
                        state_d    = ST_RESP;
                    end else begin
                        // Sub-word store: fetch the word for the merge
                        err_d     = 1'b0;
                        bus.mem_a = req_waddr_s;
                        state_d   = ST_RMW;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rdata_d = load_extend(bus.mem_rd, off_q, funct3_q);
                state_d = ST_RESP;
            end
            ST_RMW: begin
                bus.mem_we = !rst;
                bus.mem_a  = waddr_q;
                bus.mem_wd = store_merge(bus.mem_rd, wdata_q, off_q, funct3_q);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = !rst;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0000_0000;
            waddr_q  <= '0;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Response data/status straight from their registers
    always_comb begin
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

endmodule
